// File: rtl/axil_master_pkg.sv
// Shared types and constants for the Garnet configuration AXI4-lite master.
package axil_master_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WADDR = 3'd1;
  localparam logic [2:0] ST_WRESP = 3'd2;
  localparam logic [2:0] ST_RADDR = 3'd3;
  localparam logic [2:0] ST_RDATA = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // Command fields are sized for the widest supported bus and sliced down by the master.
  localparam int CMD_ADDR_MAX = 32;
  localparam int CMD_DATA_MAX = 64;

  typedef struct packed {
    logic                    write;
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] data;
  } cmd_t;

endpackage

// File: rtl/axil_watchdog.sv
// Transaction watchdog: preset on command accept, counts busy cycles, flags expiry.
module axil_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  assign expire = enable && (count_q == LAST);

  // The accept cycle is the first tick, so expiry lands TIMEOUT_CYCLES after accept.
  always_comb begin
    count_d = count_q;
    if (load)
      count_d = CW'(1);
    else if (enable && !expire)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-lite master turning register commands into bus transactions.
module axil_cfg_master
  import axil_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  logic [2:0]            state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  wd_load, wd_enable, wd_expire, complete;
  logic                  unused_cmd;

  assign wd_enable = (state_q == ST_WADDR) || (state_q == ST_WRESP) ||
                     (state_q == ST_RADDR) || (state_q == ST_RDATA);

  axil_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .load   (wd_load),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    wd_load       = 1'b0;
    complete      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = CMD_ADDR_MAX'(cmd_addr);
          cmd_d.data  = CMD_DATA_MAX'(cmd_data);
          cmd_ready_d = 1'b0;
          wd_load     = 1'b1;
          if (cmd_write) begin
            state_d   = ST_WADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      // AW and W retire independently; B is only requested once both have gone.
      ST_WADDR: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (bvalid) begin
          complete      = 1'b1;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = bresp;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (rvalid) begin
          complete      = 1'b1;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = rresp;
          rsp_data_d    = rdata;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
    // A slave answer in the expiry cycle takes precedence over the forced error.
    if (wd_expire && !complete) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = AXI_RESP_SLVERR;
      rsp_data_d    = '0;
      rsp_timeout_d = 1'b1;
      state_d       = ST_RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Latched command is pure datapath and needs no reset.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_d;
  end

  assign unused_cmd  = ^{cmd_q.write, cmd_q.addr, cmd_q.data};

  assign cmd_ready   = cmd_ready_q;
  assign awaddr      = cmd_q.addr[ADDR_WIDTH-1:0];
  assign araddr      = cmd_q.addr[ADDR_WIDTH-1:0];
  assign wdata       = cmd_q.data[DATA_WIDTH-1:0];
  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign bready      = bready_q;
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
